ysyx_23060303_wbu: RTL

//  Write-back unit directly upstream of the register file. Accepts one retired

---
 rtl/ysyx_23060303_wbu.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060303_wbu.sv
// ============================================================================
//  Module   : ysyx_23060303_wbu
//  Brief    : Write-back unit. Retires one instruction per handshake. Waits
//             for load data when needed, then aligns and extends it. Drives
//             the register-file write port and a commit pulse, one cycle each.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060303_wbu #(
    parameter int ysyx_23060303_ADDR_WIDTH = 5,
    parameter int ysyx_23060303_DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    // upstream retire channel
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [31:0]                         in_pc,
    input  logic [ysyx_23060303_ADDR_WIDTH-1:0] in_rd,
    input  logic                                in_rd_wen,
    input  logic                                in_is_load,
    input  logic [2:0]                          in_funct3,
    input  logic [1:0]                          in_addr_lo,
    input  logic [ysyx_23060303_DATA_WIDTH-1:0] in_alu_res,
    // load data return
    input  logic                                mem_rvalid,
    input  logic [ysyx_23060303_DATA_WIDTH-1:0] mem_rdata,
    // register-file write port
    output logic                                rf_wen,
    output logic [ysyx_23060303_ADDR_WIDTH-1:0] rf_waddr,
    output logic [ysyx_23060303_DATA_WIDTH-1:0] rf_wdata,
    // difftest commit
    output logic                                commit_valid,
    output logic [31:0]                         commit_pc
);

    localparam int AW = ysyx_23060303_ADDR_WIDTH;
    localparam int DW = ysyx_23060303_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WB       = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // instruction context captured at the handshake
    logic [31:0]      pc_q,      pc_d;
    logic [AW-1:0]    rd_q,      rd_d;
    logic             rd_wen_q,  rd_wen_d;
    logic [2:0]       funct3_q,  funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [DW-1:0]    alu_q,     alu_d;

    // registered outputs
    logic             rf_wen_q,       rf_wen_d;
    logic [AW-1:0]    rf_waddr_q,     rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q,     rf_wdata_d;
    logic             commit_valid_q, commit_valid_d;
    logic [31:0]      commit_pc_q,    commit_pc_d;

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [DW-1:0]    w_load_data;

    // Ready depends only on state and reset, never on the data inputs.
    assign in_ready = (state_q == ST_IDLE) && !rst;

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;

    // Select the addressed byte/half lane and extend per the load type.
    always_comb begin
        w_byte      = mem_rdata[7:0];
        w_half      = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_data = mem_rdata;
        case (addr_lo_q)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (funct3_q)
            3'b000:  w_load_data = {{(DW-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DW-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DW-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DW-16){1'b0}}, w_half};
            default: w_load_data = mem_rdata;  // lw and undefined encodings
        endcase
    end

    // Next-state, context capture and output-register next values.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        rd_wen_d       = rd_wen_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        alu_d          = alu_q;
        rf_wen_d       = 1'b0;
        commit_valid_d = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_pc_d    = commit_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pc_d      = in_pc;
                    rd_d      = in_rd;
                    rd_wen_d  = in_rd_wen;
                    funct3_d  = in_funct3;
                    addr_lo_d = in_addr_lo;
                    alu_d     = in_alu_res;
                    if (in_is_load) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        // Output flops load on this edge, so the write
                        // appears the cycle after acceptance.
                        state_d        = ST_WB;
                        rf_wen_d       = in_rd_wen && (in_rd != '0);
                        commit_valid_d = 1'b1;
                        rf_waddr_d     = in_rd;
                        rf_wdata_d     = in_alu_res;
                        commit_pc_d    = in_pc;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d        = ST_WB;
                    rf_wen_d       = rd_wen_q && (rd_q != '0);
                    commit_valid_d = 1'b1;
                    rf_waddr_d     = rd_q;
                    rf_wdata_d     = w_load_data;
                    commit_pc_d    = pc_q;
                end
            end
            ST_WB: begin
                // Outputs pulse during this state; fall back to accept.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            alu_q          <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            alu_q          <= alu_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

endmodule

`default_nettype wire
